// File: rtl/hilo_muldiv_seq.sv
// Iterative radix-2 multiply/divide sequencer for the HI/LO registers.
// Each op takes 37 cycles. LO and HI are written over the shared 32-bit data path, LO first.
module hilo_muldiv_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic        lo_we,
    output logic        hi_we,
    output logic [31:0] res_wdata,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        CALC  = 3'd2,
        FIX   = 3'd3,
        WR_LO = 3'd4,
        WR_HI = 3'd5
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        op_div_r, sign1_r, sign2_r;
    logic [31:0] src1_r, a_r, b_r, lo_r, hi_r;
    logic [63:0] acc_r;
    logic [4:0]  cnt_r;

    logic [32:0] mul_sum_s, div_rem_s, div_diff_s;
    logic        div_ge_s;
    logic [63:0] mul_next_s, div_next_s, prod_s;
    logic [31:0] fix_lo_s, fix_hi_s;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        neg32 = ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        neg64 = ~x + 64'd1;
    endfunction

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush is honoured only before the commit into WR_LO
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = (start && !flush) ? PREP : IDLE;
            PREP:    state_nxt_s = flush ? IDLE : CALC;
            CALC: begin
                if (flush) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == 5'd31) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX:     state_nxt_s = flush ? IDLE : WR_LO;
            WR_LO:   state_nxt_s = WR_HI;
            WR_HI:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // One engine step: a shift-add for multiply, or a restoring subtract for divide.
    // The dividend bits enter the remainder MSB-first from a_r.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[63:32]} + (b_r[0] ? {1'b0, a_r} : 33'd0);
        mul_next_s = {mul_sum_s, acc_r[31:1]};
        div_rem_s  = {acc_r[63:32], a_r[31]};
        div_ge_s   = (div_rem_s >= {1'b0, b_r});
        div_diff_s = div_rem_s - {1'b0, b_r};
        div_next_s = {(div_ge_s ? div_diff_s[31:0] : div_rem_s[31:0]), acc_r[30:0], div_ge_s};
    end

    // Sign fix-up and divide-by-zero result
    always_comb begin
        prod_s = (sign1_r ^ sign2_r) ? neg64(acc_r) : acc_r;
        if (!op_div_r) begin
            fix_lo_s = prod_s[31:0];
            fix_hi_s = prod_s[63:32];
        end else if (b_r == 32'd0) begin
            fix_lo_s = 32'hFFFF_FFFF;
            fix_hi_s = src1_r;
        end else begin
            fix_lo_s = (sign1_r ^ sign2_r) ? neg32(acc_r[31:0]) : acc_r[31:0];
            fix_hi_s = sign1_r ? neg32(acc_r[63:32]) : acc_r[63:32];
        end
    end

    // Operand latch, iteration engine and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_div_r <= 1'b0;
            sign1_r  <= 1'b0;
            sign2_r  <= 1'b0;
            src1_r   <= 32'd0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            acc_r    <= 64'd0;
            cnt_r    <= 5'd0;
            lo_r     <= 32'd0;
            hi_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !flush) begin
                        op_div_r <= op[1];
                        sign1_r  <= ~op[0] & src1[31];
                        sign2_r  <= ~op[0] & src2[31];
                        src1_r   <= src1;
                        a_r      <= src1;
                        b_r      <= src2;
                    end
                end
                PREP: begin
                    a_r   <= sign1_r ? neg32(a_r) : a_r;
                    b_r   <= sign2_r ? neg32(b_r) : b_r;
                    acc_r <= 64'd0;
                    cnt_r <= 5'd0;
                end
                CALC: begin
                    cnt_r <= cnt_r + 5'd1;
                    if (op_div_r) begin
                        acc_r <= div_next_s;
                        a_r   <= {a_r[30:0], 1'b0};
                    end else begin
                        acc_r <= mul_next_s;
                        b_r   <= {1'b0, b_r[31:1]};
                    end
                end
                FIX: begin
                    lo_r <= fix_lo_s;
                    hi_r <= fix_hi_s;
                end
                default: ;
            endcase
        end
    end

    // Output decode from state; only stall_req sees start directly
    always_comb begin
        stall_req = 1'b0;
        busy      = 1'b0;
        lo_we     = 1'b0;
        hi_we     = 1'b0;
        done      = 1'b0;
        res_wdata = 32'd0;
        case (state_r)
            IDLE: stall_req = start && !flush && resetn;
            PREP, CALC, FIX: begin
                stall_req = 1'b1;
                busy      = 1'b1;
            end
            WR_LO: begin
                stall_req = 1'b1;
                busy      = 1'b1;
                lo_we     = 1'b1;
                res_wdata = lo_r;
            end
            WR_HI: begin
                busy      = 1'b1;
                hi_we     = 1'b1;
                done      = 1'b1;
                res_wdata = hi_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Directed bench for hilo_muldiv_seq. Inputs change 1 ns after the rising edge.
// Outputs are sampled on the falling edge.
module tb_hilo_muldiv_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1, src2;
    logic        flush;
    logic        stall_req, busy, lo_we, hi_we, done;
    logic [31:0] res_wdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] cap_lo, cap_hi;
    int cap_lo_cyc, cap_hi_cyc, cap_done_cyc, cap_done_cnt;
    int cap_stall_cnt, cap_stall_last, cap_busy_cnt, cap_we_cnt, cap_bad;

    hilo_muldiv_seq dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .lo_we     (lo_we),
        .hi_we     (hi_we),
        .res_wdata (res_wdata),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Runs n_cyc cycles from cycle 0 (the start cycle) and records what the outputs did.
    task automatic drive_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input int flush_cyc, input bit hold_start, input int n_cyc);
        cap_lo = 32'd0; cap_hi = 32'd0;
        cap_lo_cyc = -1; cap_hi_cyc = -1; cap_done_cyc = -1; cap_done_cnt = 0;
        cap_stall_cnt = 0; cap_stall_last = -1; cap_busy_cnt = 0; cap_we_cnt = 0; cap_bad = 0;
        for (int c = 0; c < n_cyc; c++) begin
            start = (c == 0) || (hold_start && c <= 36);
            op    = o;
            src1  = (c == 0) ? a : 32'hDEAD_BEEF;
            src2  = (c == 0) ? b : 32'h0000_0003;
            flush = (c == flush_cyc);
            @(negedge clk);
            if (stall_req) begin cap_stall_cnt++; cap_stall_last = c; end
            if (busy) cap_busy_cnt++;
            if (lo_we) begin cap_lo = res_wdata; cap_lo_cyc = c; cap_we_cnt++; end
            if (hi_we) begin cap_hi = res_wdata; cap_hi_cyc = c; cap_we_cnt++; end
            if (done) begin cap_done_cyc = c; cap_done_cnt++; end
            if (lo_we && hi_we) cap_bad++;
            if (!lo_we && !hi_we && res_wdata !== 32'd0) cap_bad++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; src1 = 32'd0; src2 = 32'd0;
        #2;
        n_cmp++;
        if ({stall_req, busy, lo_we, hi_we, done, res_wdata} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {stall_req, busy, lo_we, hi_we, done, res_wdata});
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_multu();
        drive_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 40);
        n_cmp++; if (cap_lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", cap_lo); end
        n_cmp++; if (cap_lo_cyc !== 35) begin n_err++; $display("FAIL multu_lo_cycle: got %0d want 35", cap_lo_cyc); end
        n_cmp++; if (cap_hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", cap_hi); end
        n_cmp++; if (cap_hi_cyc !== 36) begin n_err++; $display("FAIL multu_hi_cycle: got %0d want 36", cap_hi_cyc); end
        n_cmp++; if (cap_done_cyc !== 36 || cap_done_cnt !== 1) begin n_err++; $display("FAIL multu_done: cycle %0d count %0d want 36/1", cap_done_cyc, cap_done_cnt); end
        n_cmp++; if (cap_bad !== 0) begin n_err++; $display("FAIL multu_strobes: %0d bad cycles want 0", cap_bad); end
    endtask

    task automatic test_mult_signed();
        drive_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, -1, 1'b0, 40);
        n_cmp++; if (cap_lo !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mult_neg_lo: got %h want fffffff1", cap_lo); end
        n_cmp++; if (cap_hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_neg_hi: got %h want ffffffff", cap_hi); end
        n_cmp++; if (cap_stall_cnt !== 36 || cap_stall_last !== 35) begin n_err++; $display("FAIL mult_stall: count %0d last %0d want 36/35", cap_stall_cnt, cap_stall_last); end
        n_cmp++; if (cap_busy_cnt !== 36) begin n_err++; $display("FAIL mult_busy: count %0d want 36", cap_busy_cnt); end
        drive_op(2'b01, 32'h1234_5678, 32'h0000_0010, -1, 1'b0, 40);
        n_cmp++; if ({cap_hi, cap_lo} !== 64'h0000_0001_2345_6780) begin n_err++; $display("FAIL multu_shift: got %h want 0000000123456780", {cap_hi, cap_lo}); end
    endtask

    task automatic test_div();
        drive_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b0, 40);
        n_cmp++; if ({cap_hi, cap_lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL div_neg7_by2: got hi:lo %h want ffffffff:fffffffd", {cap_hi, cap_lo}); end
        drive_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, 40);
        n_cmp++; if ({cap_hi, cap_lo} !== 64'h0000_0000_8000_0000) begin n_err++; $display("FAIL div_overflow: got hi:lo %h want 00000000:80000000", {cap_hi, cap_lo}); end
        drive_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, -1, 1'b0, 40);
        n_cmp++; if ({cap_hi, cap_lo} !== 64'h0000_0001_FFFF_FFFD) begin n_err++; $display("FAIL div_7_byneg2: got hi:lo %h want 00000001:fffffffd", {cap_hi, cap_lo}); end
        drive_op(2'b11, 32'h0000_0064, 32'h0000_0007, -1, 1'b0, 40);
        n_cmp++; if ({cap_hi, cap_lo} !== 64'h0000_0002_0000_000E) begin n_err++; $display("FAIL divu_100_by7: got hi:lo %h want 00000002:0000000e", {cap_hi, cap_lo}); end
        n_cmp++; if (cap_lo_cyc !== 35 || cap_hi_cyc !== 36) begin n_err++; $display("FAIL divu_timing: lo %0d hi %0d want 35/36", cap_lo_cyc, cap_hi_cyc); end
    endtask

    task automatic test_div_zero();
        drive_op(2'b11, 32'h1234_5678, 32'h0000_0000, -1, 1'b0, 40);
        n_cmp++; if ({cap_hi, cap_lo} !== 64'h1234_5678_FFFF_FFFF) begin n_err++; $display("FAIL divu_by0: got hi:lo %h want 12345678:ffffffff", {cap_hi, cap_lo}); end
        drive_op(2'b10, 32'h1234_5678, 32'h0000_0000, -1, 1'b0, 40);
        n_cmp++; if ({cap_hi, cap_lo} !== 64'h1234_5678_FFFF_FFFF) begin n_err++; $display("FAIL div_by0: got hi:lo %h want 12345678:ffffffff", {cap_hi, cap_lo}); end
        drive_op(2'b10, 32'h8765_4321, 32'h0000_0000, -1, 1'b0, 40);
        n_cmp++; if ({cap_hi, cap_lo} !== 64'h8765_4321_FFFF_FFFF) begin n_err++; $display("FAIL div_neg_by0: got hi:lo %h want 87654321:ffffffff", {cap_hi, cap_lo}); end
    endtask

    task automatic test_flush();
        int we_seen;
        we_seen = 0;
        // flush in IDLE blocks the start
        start = 1'b1; flush = 1'b1; op = 2'b10; src1 = 32'd9; src2 = 32'd2;
        @(negedge clk);
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL flush_idle_stall: got %b want 0", stall_req); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_busy: got %b want 0", busy); end
        // flush during CALC at cycle 10
        for (int c = 0; c <= 10; c++) begin
            start = (c == 0);
            op    = 2'b10; src1 = 32'hFFFF_FFF9; src2 = 32'h0000_0002;
            flush = (c == 10);
            @(negedge clk);
            if (lo_we || hi_we || done) we_seen++;
            @(posedge clk); #1;
        end
        start = 1'b0; flush = 1'b0;
        n_cmp++; if (busy !== 1'b0 || stall_req !== 1'b0) begin n_err++; $display("FAIL flush_calc_idle: busy %b stall %b at cycle 11 want 0/0", busy, stall_req); end
        drive_op(2'b11, 32'h0000_0064, 32'h0000_0007, -1, 1'b0, 40);
        n_cmp++; if (we_seen !== 0 || cap_done_cnt !== 1) begin n_err++; $display("FAIL flush_calc_writes: early strobes %0d, next done %0d want 0/1", we_seen, cap_done_cnt); end
        n_cmp++; if ({cap_hi, cap_lo} !== 64'h0000_0002_0000_000E) begin n_err++; $display("FAIL flush_next_op: got hi:lo %h want 00000002:0000000e", {cap_hi, cap_lo}); end
        // flush in WR_LO is ignored
        drive_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 35, 1'b0, 40);
        n_cmp++; if (cap_we_cnt !== 2 || cap_lo_cyc !== 35 || cap_hi_cyc !== 36) begin n_err++; $display("FAIL flush_wrlo_writes: count %0d lo %0d hi %0d want 2/35/36", cap_we_cnt, cap_lo_cyc, cap_hi_cyc); end
        n_cmp++; if ({cap_hi, cap_lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL flush_wrlo_data: got hi:lo %h want ffffffff:fffffffd", {cap_hi, cap_lo}); end
    endtask

    task automatic test_reset_mid();
        int we_seen;
        we_seen = 0;
        for (int c = 0; c < 20; c++) begin
            start = (c == 0); op = 2'b01; src1 = 32'd6; src2 = 32'd7; flush = 1'b0;
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({stall_req, busy, lo_we, hi_we, done, res_wdata} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %b, want all zero",
                     {stall_req, busy, lo_we, hi_we, done, res_wdata});
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (lo_we || hi_we || done || busy) we_seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (we_seen !== 0) begin n_err++; $display("FAIL reset_mid_activity: %0d active cycles want 0", we_seen); end
    endtask

    task automatic test_back_to_back();
        // start held high through the whole op; only the first op runs
        drive_op(2'b01, 32'h0000_0003, 32'h0000_0004, -1, 1'b1, 37);
        n_cmp++; if ({cap_hi, cap_lo} !== 64'h0000_0000_0000_000C) begin n_err++; $display("FAIL hold_start_data: got hi:lo %h want 00000000:0000000c", {cap_hi, cap_lo}); end
        n_cmp++; if (cap_stall_cnt !== 36 || cap_done_cnt !== 1) begin n_err++; $display("FAIL hold_start_stall: stall %0d done %0d want 36/1", cap_stall_cnt, cap_done_cnt); end
        // next op at cycle 37
        drive_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 40);
        n_cmp++; if ({cap_hi, cap_lo} !== 64'h0000_0000_0000_0001) begin n_err++; $display("FAIL b2b_data: got hi:lo %h want 00000000:00000001", {cap_hi, cap_lo}); end
        n_cmp++; if (cap_lo_cyc !== 35 || cap_done_cyc !== 36) begin n_err++; $display("FAIL b2b_timing: lo %0d done %0d want 35/36", cap_lo_cyc, cap_done_cyc); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_signed();
        test_div();
        test_div_zero();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: bench still running at %0t want finished", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hilo_muldiv_seq.md
# hilo_muldiv_seq

Iterative multiply/divide sequencer feeding the HI/LO registers of the register file. It accepts a mult/multu/div/divu from EX, stalls the pipeline while computing with a radix-2 shift-add/subtract engine, then writes the 64-bit result through the register file's single shared 32-bit write-data path: LO first, HI on the following cycle. It sits between EX and the HI/LO write port; its writes also drive the forwarding inputs.

## Interface
- W, 32, operand width; only 32 is supported.
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  EX presents a mult/div op this cycle
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- src1  in  W  multiplicand / dividend
- src2  in  W  multiplier / divisor
- flush  in  1  cancel in-flight op (exception/ERET)
- stall_req  out  1  hold IF..EX
- busy  out  1  state != IDLE
- lo_we  out  1  LO write strobe
- hi_we  out  1  HI write strobe
- res_wdata  out  W  data for whichever strobe is high
- done  out  1  one-cycle pulse, coincident with hi_we

## Operation
- States: IDLE, PREP, CALC, FIX, WR_LO, WR_HI.
- IDLE: on start && !flush latch op, record s1=src1[31], s2=src2[31] (signed ops only, else 0) -> PREP.
- PREP: take magnitudes |src1|, |src2| (two's complement negate if sign set); clear 64-bit accumulator and 5-bit iteration counter -> CALC.
- CALC: exactly W iterations, counter 0..31 incrementing, exit on counter==31 -> FIX.
  - Multiply: if multiplier LSB, add multiplicand into acc[63:32]; shift {carry,acc} right 1.
  - Divide (restoring): shift {rem,quot} left 1; if rem >= divisor subtract and set quot LSB.
- FIX: sign correction, then -> WR_LO. This is the commit point.
  - mult: negate 64-bit product if s1^s2.
  - div: negate quotient if s1^s2; negate remainder if s1.
  - Divisor zero (div/divu): lo = 32'hFFFFFFFF, hi = src1 as latched, regardless of sign.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (natural result of the engine; no trap).
  - Result: mult -> hi:lo = product[63:32]:[31:0]; div -> lo = quotient, hi = remainder.
- WR_LO: lo_we=1, res_wdata=lo -> WR_HI.
- WR_HI: hi_we=1, res_wdata=hi, done=1 -> IDLE.
- hi_we and lo_we are never high in the same cycle; res_wdata = 0 when neither is high.
- start while busy is ignored. No new op is accepted in the WR_HI cycle.
- flush in IDLE blocks a start in that cycle. In PREP/CALC/FIX it returns the block to IDLE next cycle with no writes and no done. In WR_LO/WR_HI it is ignored, so the 64-bit write is always atomic.

## Timing
- Reset (resetn low, asynchronous): state IDLE, counter 0, accumulator 0; stall_req, busy, lo_we, hi_we, done, res_wdata all 0.
- Reset asserted mid-operation aborts immediately and suppresses any pending write.
- Cycle 0: start accepted in IDLE. stall_req=1 combinationally from start.
- Cycle 1: PREP. Cycles 2-33: CALC. Cycle 34: FIX. Cycle 35: WR_LO. Cycle 36: WR_HI.
- stall_req=1 for cycles 0-35 and 0 in cycle 36, so the instruction leaves EX with the HI write.
- Total 37 cycles per op, fixed; there is no early exit for zero or small operands.
- busy=1 for cycles 1-36.
- Back-to-back ops: the earliest next start is cycle 37.
- All outputs except stall_req (start term) are registered-state decodes; no combinational path from src1/src2 to outputs.

## Test plan
- multu 0xFFFFFFFF * 0xFFFFFFFF -> cycle 35 lo_we, data 0x00000001; cycle 36 hi_we, data 0xFFFFFFFE, done=1.
- mult -3 (0xFFFFFFFD) * 5 -> lo 0xFFFFFFF1, hi 0xFFFFFFFF; stall_req high exactly cycles 0-35.
- div -7 / 2 -> lo 0xFFFFFFFD (-3), hi 0xFFFFFFFF (-1). Also div 0x80000000 / 0xFFFFFFFF -> lo 0x80000000, hi 0.
- divu 0x12345678 / 0 and div 0x12345678 / 0 -> lo 0xFFFFFFFF, hi 0x12345678.
- div started, flush at cycle 10 -> IDLE at cycle 11, no lo_we/hi_we/done. New start at cycle 11 completes normally. flush at cycle 35 -> both writes still occur.
- resetn low at cycle 20 of an op -> all outputs 0 at once, no writes. start held high during a busy op -> ignored; result matches the first op only.
